fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
- Shares the single read port of the asynchronous FIFO's read side among NREQ consumers in the read clock domain.
- Round-robin arbitration with bounded bursts: at most BURST words per grant.
- Drives the FIFO read enable, consumes the FIFO empty flag and read data, and returns data plus a per-consumer valid strobe tagged to the owning consumer.
- Sits between the read-side pointer/empty control and the downstream consumers.

Parameters:
- NREQ, 4, number of consumers (2..8)
- DATASIZE, 8, FIFO data width in bits
- BURST, 4, maximum words read per grant (1..15)
- IDXW, 2, width of the owner index; must satisfy 2^IDXW >= NREQ

Ports:
- rclk  in  1  read-domain clock; all logic on the rising edge
- rrst  in  1  synchronous, active-high reset, sampled on the rclk rising edge
- req  in  NREQ  per-consumer read request, level; held while the consumer wants data
- rempty  in  1  FIFO empty flag, read-clock domain
- rdata  in  DATASIZE  FIFO read data; valid the cycle after a ren the FIFO accepted
- ren  out  1  FIFO read enable, combinational
- gnt  out  NREQ  one-hot grant, registered; all zero when no owner
- dout  out  DATASIZE  registered copy of rdata
- dvalid  out  NREQ  one-hot; dout is valid for this consumer this cycle
- busy  out  1  high while state is not IDLE

Behaviour:
- Reset (rrst=1 at an rclk edge):
  - state=IDLE, gnt=0, dvalid=0, dout=0, busy=0.
  - Burst counter cnt=0.
  - Priority pointer last=NREQ-1, so consumer 0 wins first.
  - The pending-read tag is cleared.
  - Reset mid-burst aborts the burst; an in-flight word is discarded (no dvalid).
- States: IDLE, READ, RELEASE.
- IDLE:
  - If req is non-zero, choose the winner as the first index with req set, searching last+1, last+2, ... and wrapping modulo NREQ.
  - Next cycle: gnt=onehot(winner), owner=winner, cnt=0, state=READ.
  - If req is zero, stay in IDLE.
- READ:
  - ren = req[owner] & ~rempty, combinational; ren=0 in every other state.
  - Each cycle with ren=1: cnt increments and the pending tag {1, owner} is registered.
  - Leave to RELEASE at the edge where any of these holds:
    - ren=1 and cnt==BURST-1 (the last word of the burst is issued that cycle);
    - req[owner]=0;
    - rempty=1.
  - gnt drops to 0 in RELEASE.
- RELEASE:
  - One dead cycle: last=owner, cnt=0, state=IDLE.
  - Guarantees one-cycle grant spacing and fair rotation.
- Data return:
  - In the cycle after ren=1, dout<=rdata and dvalid<=onehot(tagged owner) at the next edge.
  - So dvalid rises 2 cycles after the ren cycle.
  - The data pipe runs independently of the state machine, so the last burst word is still delivered after gnt drops.
  - dvalid is high for exactly one cycle per accepted read.
- Boundary conditions:
  - rempty rising in the same cycle as the last burst word: ren=0, exit to RELEASE; no read is issued.
  - Owner drops req during READ: no ren that cycle; a word already read is still delivered.
  - Only one requester active: it is re-granted after each RELEASE, giving a maximum throughput of BURST words per BURST+2 cycles.
  - req changes during READ do not affect the current grant.
  - cnt width is 4 bits; it never exceeds BURST-1 and never wraps.

Optional Feature:
- Macro: FIFO_ARB_PRIORITY_EN.
- Defined: consumer 0 is high priority.
  - In IDLE, req[0]=1 always wins regardless of last.
  - A consumer-0 grant uses BURST words but does not update last (RELEASE leaves last unchanged), so rotation among the other consumers is preserved.
- Undefined: pure round-robin as described above; consumer 0 has no special treatment.

Test Plan:
- Reset: assert rrst for 2 cycles with req=4'b1111 -> gnt=0, ren=0, dvalid=0, busy=0; first grant after release is gnt=4'b0001.
- Rotation: req=4'b1111 held, FIFO preloaded with 32 words 0x00..0x1F -> grants in order 0,1,2,3,0,... with 4 words each.
  - Consumer 0 receives dout 0x00..0x03 with dvalid=4'b0001.
  - Consumer 1 receives 0x04..0x07.
  - There is 1 idle cycle between grants.
- Empty stop: FIFO holds 2 words, req=4'b0010 -> exactly 2 ren pulses, then RELEASE.
  - dvalid=4'b0010 twice, carrying the 2 words in order.
  - No third ren is issued while rempty=1.
- Request withdrawal: consumer 2 granted, req[2] dropped after its 1st ren -> no further ren; that 1 word is delivered 2 cycles after its ren; next grant goes to the next requester after 2.
- Reset mid-burst: rrst asserted in the cycle after the 2nd ren -> no dvalid for the in-flight word; state=IDLE, last=3.
- With FIFO_ARB_PRIORITY_EN, req=4'b1110 and then req[0] raised during consumer 1's burst -> consumer 1 finishes its burst, consumer 0 is granted next, then consumer 2 (rotation resumes after 1).

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: shares the FIFO read port among NREQ consumers using
// round-robin arbitration with bursts of at most BURST words per grant.
// Ports:
//   rclk   - read-domain clock, all logic on the rising edge
//   rrst   - synchronous active-high reset
//   req    - per-consumer level request
//   rempty - FIFO empty flag
//   rdata  - FIFO read data, valid the cycle after an accepted ren
//   ren    - FIFO read enable (combinational)
//   gnt    - registered one-hot grant, zero when no owner
//   dout   - registered copy of rdata
//   dvalid - one-hot strobe naming the consumer that owns dout
//   busy   - high whenever the arbiter is not idle
// Optional build macro FIFO_ARB_PRIORITY_EN: consumer 0 always wins in IDLE
// and its grants leave the round-robin pointer untouched.
module fifo_read_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int BURST    = 4,
    parameter int IDXW     = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [NREQ-1:0]     req,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                ren,
    output logic [NREQ-1:0]     gnt,
    output logic [DATASIZE-1:0] dout,
    output logic [NREQ-1:0]     dvalid,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RELEASE
    } state_t;

    localparam logic [3:0]      LASTCNT = 4'(BURST - 1);
    localparam logic [IDXW-1:0] LASTIDX = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [IDXW-1:0]     r_owner;
    logic [IDXW-1:0]     r_last;
    logic [3:0]          r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic                r_tag_v;
    logic [IDXW-1:0]     r_tag_idx;
    logic [DATASIZE-1:0] r_dout;
    logic [NREQ-1:0]     r_dvalid;

    logic [IDXW-1:0]     w_win;
    logic [IDXW-1:0]     w_hi;
    logic [IDXW-1:0]     w_lo;
    logic                w_hi_any;
    logic                w_own_req;
    logic                w_ren;
    logic                w_last_word;

    // Round-robin search: the lowest requester above the pointer wins;
    // if there is none, the search wraps to the lowest requester overall.
    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        w_hi_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo = IDXW'(i);
                if (IDXW'(i) > r_last) begin
                    w_hi     = IDXW'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
`ifdef FIFO_ARB_PRIORITY_EN
        if (req[0]) begin
            w_win = '0;
        end else begin
            w_win = w_hi_any ? w_hi : w_lo;
        end
`else
        w_win = w_hi_any ? w_hi : w_lo;
`endif
    end

    // The grant register is one-hot of the owner during READ, so masking
    // req with it yields the owner's request without a variable index.
    assign w_own_req   = |(req & r_gnt);
    assign w_ren       = (r_state == S_READ) & w_own_req & ~rempty;
    assign w_last_word = (r_cnt == LASTCNT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if ((w_ren && w_last_word) || !w_own_req || rempty) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= LASTIDX;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= ONE << w_win;
                        r_owner <= w_win;
                        r_cnt   <= '0;
                    end
                end
                S_READ: begin
                    // Wrap to zero on the final word so cnt never
                    // exceeds BURST-1.
                    if (w_ren) begin
                        r_cnt <= w_last_word ? 4'd0 : r_cnt + 4'd1;
                    end
                    if (w_next == S_RELEASE) begin
                        r_gnt <= '0;
                    end
                end
                S_RELEASE: begin
                    r_cnt <= '0;
`ifdef FIFO_ARB_PRIORITY_EN
                    if (r_owner != '0) begin
                        r_last <= r_owner;
                    end
`else
                    r_last <= r_owner;
`endif
                end
                default: begin
                    r_gnt <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Return pipe: runs independently of the FSM so a word read on the
    // last READ cycle is still delivered after the grant has dropped.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_tag_v   <= 1'b0;
            r_tag_idx <= '0;
            r_dout    <= '0;
            r_dvalid  <= '0;
        end else begin
            r_tag_v <= w_ren;
            if (w_ren) begin
                r_tag_idx <= r_owner;
            end
            if (r_tag_v) begin
                r_dout   <= rdata;
                r_dvalid <= ONE << r_tag_idx;
            end else begin
                r_dvalid <= '0;
            end
        end
    end

    assign ren    = w_ren;
    assign gnt    = r_gnt;
    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Testbench for fifo_read_arbiter: FIFO environment, transaction-level
// reference model and directed plus randomized stimulus.
module tb_fifo_read_arbiter;

    localparam int NREQ  = 4;
    localparam int BURST = 4;
`ifdef FIFO_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic [3:0] req = 4'h0;
    logic       rempty = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       ren;
    logic [3:0] gnt;
    logic [7:0] dout;
    logic [3:0] dvalid;
    logic       busy;

    always #5 rclk = ~rclk;

    fifo_read_arbiter #(
        .NREQ(NREQ), .DATASIZE(8), .BURST(BURST), .IDXW(2)
    ) dut (
        .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty),
        .rdata(rdata), .ren(ren), .gnt(gnt), .dout(dout),
        .dvalid(dvalid), .busy(busy)
    );

    typedef struct {
        int         due;
        int         own;
        logic [7:0] val;
    } dl_t;

    typedef struct {
        logic [3:0] dv;
        logic [7:0] d;
    } gt_t;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // environment FIFO (pops on the DUT's ren)
    logic [7:0] fq[$];
    logic [7:0] push_val = 8'h00;
    logic       prev_ren = 1'b0;

    // reference model
    int         m_owner = -1;
    int         m_used = 0;
    int         m_last = NREQ - 1;
    bit         m_rest = 1'b0;
    logic [7:0] mq[$];
    dl_t        dq[$];

    // logs for literal checks
    logic [3:0] glog[$];
    gt_t        got[$];
    logic [3:0] prev_gnt = 4'h0;
    int         ren_cnt = 0;

    // stimulus
    logic       t_rst = 1'b1;
    logic [3:0] t_req = 4'h0;
    int         t_push = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        logic [3:0] b;
        if (PRIO && r[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            b = 4'(1) << ((last + k) % NREQ);
            if ((r & b) != 4'h0) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        logic [3:0] e_gnt;
        logic [3:0] e_dv;
        logic [3:0] omask;
        logic [7:0] e_d;
        logic       e_ren;
        logic       e_busy;
        bit         active;
        bit         m_empty;
        dl_t        nd;
        @(posedge rclk);
        #1;
        if (prev_ren === 1'b1) begin
            if (fq.size() > 0) rdata = fq.pop_front();
            else rdata = 8'hEE;
        end
        for (int p = 0; p < t_push; p++) begin
            fq.push_back(push_val);
            mq.push_back(push_val);
            push_val = push_val + 8'd1;
        end
        rempty = (fq.size() == 0);
        req = t_req;
        rrst = t_rst;
        #4;
        active = (m_owner >= 0) && !m_rest;
        omask = active ? (4'(1) << m_owner) : 4'h0;
        m_empty = (mq.size() == 0);
        e_gnt = omask;
        e_busy = (m_owner >= 0);
        e_ren = ((req & omask) != 4'h0) && !m_empty;
        e_dv = 4'h0;
        e_d = 8'h00;
        if (dq.size() > 0 && dq[0].due == cyc) begin
            e_dv = 4'(1) << dq[0].own;
            e_d = dq[0].val;
            void'(dq.pop_front());
        end
        if (armed) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ren", 32'(ren), 32'(e_ren));
            chk("dvalid", 32'(dvalid), 32'(e_dv));
            if (e_dv != 4'h0) chk("dout", 32'(dout), 32'(e_d));
            if (ren === 1'b1) ren_cnt++;
            if (dvalid !== 4'h0) begin
                gt_t g;
                g.dv = dvalid;
                g.d = dout;
                got.push_back(g);
            end
            if (gnt !== 4'h0 && prev_gnt === 4'h0) glog.push_back(gnt);
        end
        prev_gnt = gnt;
        prev_ren = ren;
        if (e_ren) begin
            nd.due = cyc + 2;
            nd.own = m_owner;
            nd.val = mq.pop_front();
            dq.push_back(nd);
        end
        if (t_rst) begin
            m_owner = -1;
            m_used = 0;
            m_last = NREQ - 1;
            m_rest = 1'b0;
            dq.delete();
            armed = 1'b1;
        end else if (m_owner < 0) begin
            if (req != 4'h0) begin
                m_owner = pick(req, m_last);
                m_used = 0;
            end
        end else if (m_rest) begin
            if (!(PRIO && m_owner == 0)) m_last = m_owner;
            m_owner = -1;
            m_rest = 1'b0;
        end else begin
            if (e_ren) m_used++;
            if ((e_ren && m_used == BURST) || (req & omask) == 4'h0 ||
                m_empty) begin
                m_rest = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle_n(input int n);
        t_req = 4'h0;
        t_push = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit hit;

        // reset held two cycles with all requests up
        t_rst = 1'b1;
        t_req = 4'hF;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ren", 32'(ren), 32'h0);
        chk("rst_dvalid", 32'(dvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // rotation over 32 preloaded words
        glog.delete();
        got.delete();
        t_rst = 1'b0;
        t_push = 32;
        step();
        t_push = 0;
        for (int i = 0; i < 70; i++) step();
        chk("rot_first_gnt", 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'h1);
        chk("rot_ngrants", 32'(glog.size() >= 5), 32'h1);
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                chk("rot_order", 32'(glog[i]), 32'(4'(1) << (i % 4)));
        end
        chk("rot_words", 32'(got.size()), 32'd32);
        if (got.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("rot_dv", 32'(got[i].dv), (i < 4) ? 32'h1 : 32'h2);
                chk("rot_data", 32'(got[i].d), 32'(i));
            end
        end

        // empty stop: two words for consumer 1 only
        idle_n(4);
        got.delete();
        ren_cnt = 0;
        t_req = 4'b0010;
        t_push = 2;
        step();
        t_push = 0;
        for (int i = 0; i < 11; i++) step();
        chk("emp_rens", 32'(ren_cnt), 32'd2);
        chk("emp_words", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("emp_dv0", 32'(got[0].dv), 32'h2);
            chk("emp_d0", 32'(got[0].d), 32'h20);
            chk("emp_dv1", 32'(got[1].dv), 32'h2);
            chk("emp_d1", 32'(got[1].d), 32'h21);
        end

        // request withdrawal by consumer 2 after its first read
        idle_n(4);
        glog.delete();
        got.delete();
        t_req = 4'b1100;
        t_push = 8;
        step();
        t_push = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (ren === 1'b1 && gnt === 4'b0100) hit = 1'b1;
        end
        chk("wd_wait", 32'(hit), 32'h1);
        t_req = 4'b1000;
        for (int i = 0; i < 10; i++) step();
        begin
            int n2;
            n2 = 0;
            foreach (got[i]) if (got[i].dv == 4'b0100) n2++;
            chk("wd_words", 32'(n2), 32'd1);
        end
        chk("wd_g0", 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'h4);
        chk("wd_g1", 32'(glog.size() > 1 ? glog[1] : 4'h0), 32'h8);

        // reset in the cycle after the second read of a burst
        idle_n(4);
        got.delete();
        t_req = 4'b0001;
        t_push = 8;
        step();
        t_push = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (ren === 1'b1 && gnt === 4'b0001) hit = 1'b1;
        end
        chk("mr_wait", 32'(hit), 32'h1);
        step();
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        t_req = 4'hF;
        step();
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_gnt", 32'(gnt), 32'h0);
        chk("mr_words", 32'(got.size()), 32'd1);
        step();
        chk("mr_regrant", 32'(gnt), 32'h1);

`ifdef FIFO_ARB_PRIORITY_EN
        // consumer 0 raised during consumer 1's burst
        idle_n(4);
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        glog.delete();
        t_req = 4'b1110;
        t_push = 20;
        step();
        t_push = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (gnt === 4'b0010) hit = 1'b1;
        end
        chk("pr_wait1", 32'(hit), 32'h1);
        t_req = 4'b1111;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (gnt === 4'b0001) hit = 1'b1;
        end
        chk("pr_wait0", 32'(hit), 32'h1);
        t_req = 4'b1110;
        for (int i = 0; i < 15; i++) step();
        chk("pr_g0", 32'(glog.size() > 0 ? glog[0] : 4'h0), 32'h2);
        chk("pr_g1", 32'(glog.size() > 1 ? glog[1] : 4'h0), 32'h1);
        chk("pr_g2", 32'(glog.size() > 2 ? glog[2] : 4'h0), 32'h4);
`endif

        // randomized traffic against the model
        idle_n(4);
        for (int i = 0; i < 2500; i++) begin
            t_rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) t_req[b] = ~t_req[b];
            if (fq.size() < 40 && $urandom_range(0, 2) == 0)
                t_push = $urandom_range(1, 3);
            else
                t_push = 0;
            step();
        end
        t_rst = 1'b0;
        idle_n(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
